// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 16;
   localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

   // Counter width able to hold the value WIDTH.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next_c,
   output logic             q_bit_c
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem_in < divisor always, so the difference fits WIDTH+1 bits with a valid sign bit.
   always_comb begin
      shifted    = {rem_in, bit_in};
      diff       = shifted - {1'b0, divisor};
      q_bit_c    = ~diff[WIDTH];
      rem_next_c = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider with signed/unsigned mode and start/busy/done handshake.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             invalid_flag,
   output logic             negative,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state, state_next;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem_w;
   logic [CW-1:0]    cnt;
   logic             sign_q, sign_r, div0, ovf;

   logic             accept_c;
   logic             y_zero_c, ovf_c;
   logic [WIDTH-1:0] x_abs_c, y_abs_c;
   logic [WIDTH-1:0] rem_step_c, quo_fix_c, rem_fix_c;
   logic             q_bit_c;

   // Operand conditioning; the most negative value maps to its unsigned magnitude.
   always_comb begin
      x_abs_c   = (signed_mode && x[WIDTH-1]) ? WIDTH'(-x) : x;
      y_abs_c   = (signed_mode && y[WIDTH-1]) ? WIDTH'(-y) : y;
      y_zero_c  = (y == '0);
      ovf_c     = signed_mode && (x == {1'b1, {(WIDTH-1){1'b0}}}) && (y == '1);
      quo_fix_c = sign_q ? WIDTH'(-dvd) : dvd;
      rem_fix_c = sign_r ? WIDTH'(-rem_w) : rem_w;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in     (rem_w),
      .bit_in     (dvd[WIDTH-1]),
      .divisor    (dvs),
      .rem_next_c (rem_step_c),
      .q_bit_c    (q_bit_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; a zero divisor skips the iteration entirely.
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept_c   = 1'b1;
               state_next = y_zero_c ? FINISH : CALC;
            end
         end
         CALC:    if (cnt == CW'(1)) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand capture, one quotient bit per cycle, sign fix-up and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy         <= 1'b0;
         done         <= 1'b0;
         quo          <= '0;
         rem          <= '0;
         invalid_flag <= 1'b0;
         negative     <= 1'b0;
         zero         <= 1'b0;
         cout         <= 1'b0;
         overflow     <= 1'b0;
         dvd          <= '0;
         dvs          <= '0;
         rem_w        <= '0;
         cnt          <= '0;
         sign_q       <= 1'b0;
         sign_r       <= 1'b0;
         div0         <= 1'b0;
         ovf          <= 1'b0;
      end else begin
         busy <= (state_next != IDLE);
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  dvs  <= y_abs_c;
                  cnt  <= CW'(WIDTH);
                  div0 <= y_zero_c;
                  ovf  <= ovf_c;
                  if (y_zero_c) begin
                     // Quotient all ones, remainder is the raw dividend.
                     dvd    <= '1;
                     rem_w  <= x;
                     sign_q <= 1'b0;
                     sign_r <= 1'b0;
                  end else begin
                     dvd    <= x_abs_c;
                     rem_w  <= '0;
                     sign_q <= signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
                     sign_r <= signed_mode & x[WIDTH-1];
                  end
               end
            end
            CALC: begin
               rem_w <= rem_step_c;
               dvd   <= {dvd[WIDTH-2:0], q_bit_c};
               cnt   <= cnt - CW'(1);
            end
            FINISH: begin
               quo          <= quo_fix_c;
               rem          <= rem_fix_c;
               done         <= 1'b1;
               negative     <= quo_fix_c[WIDTH-1];
               zero         <= (quo_fix_c == '0);
               invalid_flag <= div0;
               overflow     <= ovf;
               cout         <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
